// File: rtl/iir_coef_ctrl.sv
// Coefficient and sequencing controller for the Q15 biquad IIR datapath.
// Host writes land in a shadow bank. A commit swaps the whole shadow bank into
// the active bank at a sample gap, or forced after MAX_WAIT cycles. The swap can
// be followed by a filter flush, and then a settle window that masks out_valid_o.
module iir_coef_ctrl #(
    parameter int unsigned CW        = 32,
    parameter int unsigned FLUSH_LEN = 2,
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned MAX_WAIT  = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid_i,
    output logic          cfg_ready_o,
    input  logic [2:0]    cfg_addr_i,
    input  logic [CW-1:0] cfg_data_i,
    output logic          cfg_err_o,
    input  logic          samp_valid_i,
    output logic [CW-1:0] b0_o,
    output logic [CW-1:0] b1_o,
    output logic [CW-1:0] b2_o,
    output logic [CW-1:0] a1_o,
    output logic [CW-1:0] a2_o,
    output logic          filt_rst_o,
    output logic          out_valid_o,
    output logic          busy_o
);

    localparam int unsigned CntW = 16;
    localparam logic [CW-1:0] B0Unity = CW'(32768);

    typedef enum logic [2:0] {StIdle, StLoaded, StPending, StFlush, StSettle} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_q, wait_d;
    logic [CntW-1:0] cnt_q, cnt_d;   // flush length in StFlush, sample count in StSettle
    logic            flush_q, flush_d;
    logic            filt_rst_q, out_valid_q, err_q;
    logic            fire, swap, suppress;

    logic [CW-1:0] sh_b0_q, sh_b1_q, sh_b2_q, sh_a1_q, sh_a2_q;
    logic [CW-1:0] act_b0_q, act_b1_q, act_b2_q, act_a1_q, act_a2_q;

    // Next-state logic, handshake, and output masking.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        cnt_d       = cnt_q;
        flush_d     = flush_q;
        cfg_ready_o = 1'b0;
        busy_o      = 1'b0;
        fire        = 1'b0;
        swap        = 1'b0;
        suppress    = 1'b0;
        case (state_q)
            StIdle, StLoaded: begin
                cfg_ready_o = 1'b1;
                fire        = cfg_valid_i;
                if (fire) begin
                    if (cfg_addr_i <= 3'd4) begin
                        state_d = StLoaded;
                    end else if (cfg_addr_i == 3'd5) begin
                        state_d = StPending;
                        flush_d = cfg_data_i[0];
                        wait_d  = '0;
                    end
                end
            end
            StPending: begin
                busy_o = 1'b1;
                // Swap in a sample gap, or force it once the wait budget runs out.
                if (!samp_valid_i || wait_q == CntW'(MAX_WAIT - 1)) begin
                    swap     = 1'b1;
                    suppress = 1'b1;
                    wait_d   = '0;
                    cnt_d    = '0;
                    if (flush_q) begin
                        state_d = StFlush;
                    end else begin
                        state_d = (SETTLE == 0) ? StIdle : StSettle;
                    end
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            StFlush: begin
                busy_o   = 1'b1;
                suppress = 1'b1;
                if (cnt_q == CntW'(FLUSH_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = (SETTLE == 0) ? StIdle : StSettle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StSettle: begin
                busy_o   = 1'b1;
                suppress = 1'b1;
                if (samp_valid_i) begin
                    if (cnt_q == CntW'(SETTLE - 1)) begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state, counters and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wait_q      <= '0;
            cnt_q       <= '0;
            flush_q     <= 1'b0;
            filt_rst_q  <= 1'b1;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            filt_rst_q  <= (state_d == StFlush);
            out_valid_q <= samp_valid_i & ~suppress;
            err_q       <= fire & cfg_addr_i[2] & cfg_addr_i[1];
        end
    end

    // Shadow bank: host writes to addresses 0-4.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_b0_q <= B0Unity;
            sh_b1_q <= '0;
            sh_b2_q <= '0;
            sh_a1_q <= '0;
            sh_a2_q <= '0;
        end else if (fire) begin
            case (cfg_addr_i)
                3'd0:    sh_b0_q <= cfg_data_i;
                3'd1:    sh_b1_q <= cfg_data_i;
                3'd2:    sh_b2_q <= cfg_data_i;
                3'd3:    sh_a1_q <= cfg_data_i;
                3'd4:    sh_a2_q <= cfg_data_i;
                default: ;
            endcase
        end
    end

    // Active bank: all five coefficients load on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_b0_q <= B0Unity;
            act_b1_q <= '0;
            act_b2_q <= '0;
            act_a1_q <= '0;
            act_a2_q <= '0;
        end else if (swap) begin
            act_b0_q <= sh_b0_q;
            act_b1_q <= sh_b1_q;
            act_b2_q <= sh_b2_q;
            act_a1_q <= sh_a1_q;
            act_a2_q <= sh_a2_q;
        end
    end

    assign b0_o        = act_b0_q;
    assign b1_o        = act_b1_q;
    assign b2_o        = act_b2_q;
    assign a1_o        = act_a1_q;
    assign a2_o        = act_a2_q;
    assign filt_rst_o  = filt_rst_q;
    assign out_valid_o = out_valid_q;
    assign cfg_err_o   = err_q;

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// Directed bench for iir_coef_ctrl with default parameters.
module tb_iir_coef_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [2:0]  cfg_addr = 3'd0;
    logic [31:0] cfg_data = 32'd0;
    logic        cfg_err;
    logic        samp_valid = 1'b0;
    logic [31:0] b0, b1, b2, a1, a2;
    logic        filt_rst, out_valid, busy;

    int checks = 0;
    int failures = 0;
    logic ok;

    iir_coef_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_addr_i   (cfg_addr),
        .cfg_data_i   (cfg_data),
        .cfg_err_o    (cfg_err),
        .samp_valid_i (samp_valid),
        .b0_o         (b0),
        .b1_o         (b1),
        .b2_o         (b2),
        .a1_o         (a1),
        .a2_o         (a2),
        .filt_rst_o   (filt_rst),
        .out_valid_o  (out_valid),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [2:0] addr, input logic [31:0] data);
        cfg_valid = 1'b1;
        cfg_addr  = addr;
        cfg_data  = data;
    endtask

    initial begin
        // Reset and idle defaults
        tick(); tick(); tick();
        chk("rst_filt_rst", {31'd0, filt_rst}, 32'd1);
        rst = 1'b0;
        chk("rel_filt_rst_first", {31'd0, filt_rst}, 32'd1);
        tick();
        chk("rel_filt_rst_after", {31'd0, filt_rst}, 32'd0);
        chk("rst_b0", b0, 32'd32768);
        chk("rst_b1", b1, 32'd0);
        chk("rst_a2", a2, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Non-flushing commit at a sample gap
        cfg(3'd0, 32'd16384);
        tick();
        chk("loaded_b0_unchanged", b0, 32'd32768);
        cfg(3'd3, 32'hFFFF_E0C0);  // -8000
        tick();
        cfg(3'd5, 32'd0);
        tick();
        chk("pend_busy", {31'd0, busy}, 32'd1);
        chk("pend_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        cfg_valid = 1'b0;
        tick();
        chk("swap_b0", b0, 32'd16384);
        chk("swap_a1", a1, 32'hFFFF_E0C0);
        chk("swap_filt_rst", {31'd0, filt_rst}, 32'd0);
        samp_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            ok = ok & ~out_valid;
        end
        chk("settle_suppressed", {31'd0, ok}, 32'd1);
        chk("settle_done_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("fifth_out_valid", {31'd0, out_valid}, 32'd1);
        samp_valid = 1'b0;
        tick();
        chk("gap_out_valid", {31'd0, out_valid}, 32'd0);

        // Flushing commit
        cfg(3'd5, 32'd1);
        tick();
        cfg_valid = 1'b0;
        chk("fl_pend_filt_rst", {31'd0, filt_rst}, 32'd0);
        tick();
        chk("fl_cyc1_filt_rst", {31'd0, filt_rst}, 32'd1);
        chk("fl_cyc1_ready", {31'd0, cfg_ready}, 32'd0);
        tick();
        chk("fl_cyc2_filt_rst", {31'd0, filt_rst}, 32'd1);
        tick();
        chk("fl_end_filt_rst", {31'd0, filt_rst}, 32'd0);
        chk("fl_settle_busy", {31'd0, busy}, 32'd1);
        chk("fl_settle_ready", {31'd0, cfg_ready}, 32'd0);
        samp_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        samp_valid = 1'b0;
        chk("fl_idle_ready", {31'd0, cfg_ready}, 32'd1);

        // Forced swap with samp_valid held high
        cfg(3'd1, 32'd123);
        tick();
        cfg(3'd5, 32'd0);
        tick();
        cfg_valid  = 1'b0;
        samp_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 254; i++) begin
            tick();
            ok = ok & busy & (b1 == 32'd0) & ~filt_rst;
        end
        chk("force_wait_hold", {31'd0, ok}, 32'd1);
        tick();
        chk("force_swap_b1", b1, 32'd123);
        chk("force_no_flush", {31'd0, filt_rst}, 32'd0);
        chk("force_settle_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("force_idle_busy", {31'd0, busy}, 32'd0);
        samp_valid = 1'b0;

        // Invalid address write
        cfg(3'd6, 32'd5);
        tick();
        cfg_valid = 1'b0;
        chk("err_pulse", {31'd0, cfg_err}, 32'd1);
        chk("err_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("err_single", {31'd0, cfg_err}, 32'd0);

        // Write held during PENDING/SETTLE is stalled until idle
        cfg(3'd5, 32'd0);
        tick();
        cfg(3'd2, 32'd777);
        tick();
        chk("stall_b2_old", b2, 32'd0);
        chk("stall_b0", b0, 32'd16384);
        samp_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("stall_ready_low", {31'd0, cfg_ready}, 32'd0);
        tick();
        chk("stall_ready_high", {31'd0, cfg_ready}, 32'd1);
        samp_valid = 1'b0;
        tick();
        cfg(3'd5, 32'd0);
        tick();
        cfg_valid = 1'b0;
        tick();
        chk("stall_b2_new", b2, 32'd777);
        samp_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        samp_valid = 1'b0;
        chk("stall_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of FLUSH
        cfg(3'd2, 32'd1000);
        tick();
        cfg(3'd5, 32'd1);
        tick();
        cfg_valid = 1'b0;
        tick();
        chk("rf_swap_b2", b2, 32'd1000);
        chk("rf_in_flush", {31'd0, filt_rst}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rf_b2_default", b2, 32'd0);
        chk("rf_b0_default", b0, 32'd32768);
        chk("rf_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        cfg(3'd5, 32'd0);
        tick();
        cfg_valid = 1'b0;
        tick();
        chk("rf_recommit_b2", b2, 32'd0);
        chk("rf_recommit_b0", b0, 32'd32768);
        chk("rf_recommit_a1", a1, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
